unidade_controle: RTL
=====================

# unidade_controle

Multicycle control unit for the RV64 datapath (`fd`). It sequences each instruction through fetch, decode, execute, memory and write-back phases. From the opcode returned by the datapath and the ALU flags, it drives every datapath strobe and select. It also provides explicit PC and instruction-register load enables, a run/hold input, a halt indicator and a retired-instruction counter.

## Interface
Parameters:
- `CNT_BITS`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `run`  in  1  1: fetch new instructions; 0: hold in FETCH.
- `opcode`  in  7  opcode from the instruction register.
- `alu_flags`  in  4  bit0 zero, bit1 MSB, bits 3:2 unused.
- `ir_we`  out  1  load instruction register.
- `pc_we`  out  1  update PC.
- `d_mem_we`  out  1  data memory write.
- `rf_we`  out  1  register file write.
- `alu_cmd`  out  4  immediate/ALU format: R=0000, I=0001, S=0010, SB=0011, U=0100, UJ=0101.
- `alu_src`  out  1  0: rf, 1: imm.
- `pc_src`  out  1  0: +4, 1: +imm.
- `rf_src`  out  1  0: alu, 1: d_mem.
- `halted`  out  1  illegal opcode seen; sticky until reset.
- `retired`  out  CNT_BITS  count of completed instructions.

## Operation
- Instruction classes, decoded from `opcode`:
  - R: 0110011
  - LD: 0000011
  - ADDI: 0010011
  - SD: 0100011
  - BEQ: 1100011
  - JAL: 1101111 (link register not written)
  - Any other opcode: ILLEGAL.
- The class register is loaded only at the end of DECODE. In every later state, all outputs depend only on state plus the class register, never on live `opcode`.
- States and transitions:
  - FETCH:
    - `run`=1: `ir_we`=1, next DECODE.
    - `run`=0: all strobes 0, stay in FETCH.
  - DECODE: latch class.
    - ILLEGAL → HALT.
    - BEQ/JAL → BRANCH.
    - Otherwise → EXEC.
  - EXEC: ALU computes.
    - LD/SD → MEM.
    - R/ADDI → WB.
  - MEM:
    - SD: `d_mem_we`=1, `pc_we`=1, next FETCH.
    - LD: next WB.
  - WB: `rf_we`=1, `pc_we`=1, `rf_src`=1 for LD, 0 otherwise; next FETCH.
  - BRANCH: `pc_we`=1, next FETCH.
    - BEQ: `pc_src` = `alu_flags[0]`.
    - JAL: `pc_src`=1.
  - HALT: `halted`=1, all strobes 0, no exit except reset.
- Static selects, valid from EXEC onward:
  - `alu_src` = 1 for LD, SD, ADDI; 0 for R and BEQ.
  - `alu_cmd` = R for R; I for LD and ADDI; S for SD; SB for BEQ; UJ for JAL.
  - `pc_src` = 0 everywhere except BRANCH.
- `retired` increments by 1 on every cycle with `pc_we`=1 and wraps modulo 2^CNT_BITS. ILLEGAL instructions are not counted.
- Exactly one of `rf_we`/`d_mem_we` is asserted per instruction at most, for one cycle. `pc_we` is asserted exactly once per legal instruction.

## Timing
- Reset (async, any state): state=FETCH, class=R, `retired`=0. All outputs are 0 (`alu_cmd`=0000, `halted`=0) while `rst_n`=0.
- Cycles per instruction, counted from the FETCH cycle with `run`=1:
  - R/ADDI: 4
  - LD: 5
  - SD: 4
  - BEQ/JAL: 3
- `opcode` must be valid in the DECODE cycle, one cycle after `ir_we`.
- `alu_flags` are sampled combinationally in BRANCH. The datapath has had EXEC-equivalent settling since DECODE because `alu_cmd` and `alu_src` are already driven in BRANCH.
- All strobes are Moore outputs (state plus class register) except `ir_we` and `pc_src`, which depend on `run` and `alu_flags` respectively.
- `run` deasserted mid-instruction has no effect; it is only sampled in FETCH.
- Reset released mid-cycle: the first active edge starts in FETCH.

## Test plan
- Reset, then R opcode 0110011 with `run`=1 → strobes: `ir_we` in cycle 0, `rf_we`=1 and `pc_we`=1 only in cycle 3 with `alu_cmd`=0000, `alu_src`=0, `rf_src`=0; `retired`=1.
- LD 0000011 → MEM in cycle 3; cycle 4 has `rf_we`=1, `rf_src`=1, `alu_src`=1, `alu_cmd`=0001. SD 0100011 → cycle 3 has `d_mem_we`=1, `pc_we`=1, `rf_we`=0.
- BEQ with `alu_flags`=0001 → cycle 2 has `pc_we`=1, `pc_src`=1. With `alu_flags`=0000 → `pc_src`=0. Both take 3 cycles.
- `run`=0 for 5 cycles after reset → no strobes, `retired`=0. Raise `run` → fetch begins on that edge.
- Opcode 1111111 → HALT after DECODE, `halted`=1 permanently, `retired` unchanged. Assert `rst_n`=0 mid-HALT → `halted`=0 immediately, state FETCH.
- CNT_BITS=4: retire 16 ADDIs → `retired` wraps 15→0. Pulse `rst_n` low during an LD's MEM state → no `rf_we` issued, restart in FETCH.

Source files
------------

// File: rtl/unidade_controle.sv
// Multicycle control unit for the RV64 datapath: sequences fetch/decode/execute/
// memory/write-back and drives all datapath strobes from state plus latched class.
module unidade_controle #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic [3:0]          alu_flags,
  output logic                ir_we,
  output logic                pc_we,
  output logic                d_mem_we,
  output logic                rf_we,
  output logic [3:0]          alu_cmd,
  output logic                alu_src,
  output logic                pc_src,
  output logic                rf_src,
  output logic                halted,
  output logic [CNT_BITS-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R    = 3'd0,
    C_LD   = 3'd1,
    C_ADDI = 3'd2,
    C_SD   = 3'd3,
    C_BEQ  = 3'd4,
    C_JAL  = 3'd5,
    C_ILL  = 3'd6
  } class_t;

  function automatic class_t decode_class(input logic [6:0] op);
    case (op)
      7'b0110011: decode_class = C_R;
      7'b0000011: decode_class = C_LD;
      7'b0010011: decode_class = C_ADDI;
      7'b0100011: decode_class = C_SD;
      7'b1100011: decode_class = C_BEQ;
      7'b1101111: decode_class = C_JAL;
      default:    decode_class = C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] class_alu_cmd(input class_t cl);
    case (cl)
      C_R:          class_alu_cmd = 4'b0000;
      C_LD, C_ADDI: class_alu_cmd = 4'b0001;
      C_SD:         class_alu_cmd = 4'b0010;
      C_BEQ:        class_alu_cmd = 4'b0011;
      C_JAL:        class_alu_cmd = 4'b0101;
      default:      class_alu_cmd = 4'b0000;
    endcase
  endfunction

  function automatic logic class_alu_src(input class_t cl);
    case (cl)
      C_LD, C_SD, C_ADDI: class_alu_src = 1'b1;
      default:            class_alu_src = 1'b0;
    endcase
  endfunction

  state_t                state_q, state_d;
  class_t                class_q, class_d;
  logic                  pc_we_q, pc_we_d;
  logic                  d_mem_we_q, d_mem_we_d;
  logic                  rf_we_q, rf_we_d;
  logic                  rf_src_q, rf_src_d;
  logic                  halted_q, halted_d;
  logic                  alu_src_q, alu_src_d;
  logic [3:0]            alu_cmd_q, alu_cmd_d;
  logic [CNT_BITS-1:0]   retired_q, retired_d;
  logic                  datapath_phase_s;
  logic                  unused_flags_s;

  assign unused_flags_s = ^alu_flags[3:1];

  // Next-state and class-latch logic; class only changes at the end of DECODE.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_FETCH: begin
        if (run) state_d = S_DECODE;
        else     state_d = S_FETCH;
      end
      S_DECODE: begin
        class_d = decode_class(opcode);
        case (class_d)
          C_ILL:        state_d = S_HALT;
          C_BEQ, C_JAL: state_d = S_BRANCH;
          default:      state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (class_q == C_LD || class_q == C_SD) state_d = S_MEM;
        else                                    state_d = S_WB;
      end
      S_MEM: begin
        if (class_q == C_SD) state_d = S_FETCH;
        else                 state_d = S_WB;
      end
      S_WB:     state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore strobes are precomputed from the next state so they leave a flop.
  always_comb begin
    datapath_phase_s = (state_d == S_EXEC) || (state_d == S_MEM) ||
                       (state_d == S_WB)   || (state_d == S_BRANCH);
    rf_we_d    = (state_d == S_WB);
    rf_src_d   = (state_d == S_WB) && (class_d == C_LD);
    d_mem_we_d = (state_d == S_MEM) && (class_d == C_SD);
    pc_we_d    = (state_d == S_WB) || (state_d == S_BRANCH) || d_mem_we_d;
    halted_d   = (state_d == S_HALT);
    if (datapath_phase_s) begin
      alu_cmd_d = class_alu_cmd(class_d);
      alu_src_d = class_alu_src(class_d);
    end else begin
      alu_cmd_d = 4'b0000;
      alu_src_d = 1'b0;
    end
    retired_d = retired_q + CNT_BITS'(pc_we_q);
  end

  // State, class, registered strobes and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      class_q    <= C_R;
      pc_we_q    <= 1'b0;
      d_mem_we_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_src_q   <= 1'b0;
      halted_q   <= 1'b0;
      alu_cmd_q  <= 4'b0000;
      alu_src_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      class_q    <= class_d;
      pc_we_q    <= pc_we_d;
      d_mem_we_q <= d_mem_we_d;
      rf_we_q    <= rf_we_d;
      rf_src_q   <= rf_src_d;
      halted_q   <= halted_d;
      alu_cmd_q  <= alu_cmd_d;
      alu_src_q  <= alu_src_d;
      retired_q  <= retired_d;
    end
  end

  // ir_we follows run live in FETCH; pc_src follows the zero flag live in BRANCH.
  always_comb begin
    ir_we = rst_n && run && (state_q == S_FETCH);
    if (state_q == S_BRANCH) begin
      if (class_q == C_JAL) pc_src = 1'b1;
      else                  pc_src = alu_flags[0];
    end else begin
      pc_src = 1'b0;
    end
  end

  assign pc_we    = pc_we_q;
  assign d_mem_we = d_mem_we_q;
  assign rf_we    = rf_we_q;
  assign rf_src   = rf_src_q;
  assign halted   = halted_q;
  assign alu_cmd  = alu_cmd_q;
  assign alu_src  = alu_src_q;
  assign retired  = retired_q;

endmodule
